// File: rtl/mul_div_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : mul_div_unit_if
// Purpose  : Request/response bundle between the register bank read ports,
//            the mul/div unit and the register bank write port.
// Revision : 1.0  initial release
// ============================================================================
interface mul_div_unit_if #(
  parameter int WIDTH      = 64,
  parameter int REG_ADDR_W = 5
);

  logic                  start;
  logic [1:0]            op;
  logic [WIDTH-1:0]      operand_a;
  logic [WIDTH-1:0]      operand_b;
  logic [REG_ADDR_W-1:0] dest_reg;

  logic                  busy;
  logic                  done;
  logic [WIDTH-1:0]      result;
  logic [REG_ADDR_W-1:0] result_reg;
  logic                  wb_en;

  // Issuing side: supplies requests, observes status and write-back
  modport master (
    output start, op, operand_a, operand_b, dest_reg,
    input  busy, done, result, result_reg, wb_en
  );

  // Unit side: consumes requests, produces status and write-back
  modport slave (
    input  start, op, operand_a, operand_b, dest_reg,
    output busy, done, result, result_reg, wb_en
  );

endinterface
`default_nettype wire

// File: rtl/mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : mul_div_unit
// Purpose  : Iterative unsigned multiply / divide unit. One operation at a
//            time, WIDTH iterations each (shift-add multiply, restoring
//            divide), start/busy/done handshake, registered write-back.
// Revision : 1.0  initial release
// ============================================================================
module mul_div_unit #(
  parameter int WIDTH      = 64,
  parameter int REG_ADDR_W = 5
) (
  input  wire logic      clk,
  input  wire logic      rst_n,
  mul_div_unit_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH);

  localparam logic [1:0] OP_MUL   = 2'b00;
  localparam logic [1:0] OP_MULHU = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_REMU  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  // Latched request
  logic [1:0]            op_q, op_d;
  logic [REG_ADDR_W-1:0] dest_q, dest_d;
  // Multiplicand for MUL/MULHU, divisor for DIVU/REMU
  logic [WIDTH-1:0]      opnd_q, opnd_d;

  // Multiply datapath: {high accumulator, remaining multiplier bits}
  logic [2*WIDTH-1:0]    prod_q, prod_d;
  // Divide datapath: partial remainder and dividend/quotient shifter
  logic [WIDTH-1:0]      rem_q, rem_d;
  logic [WIDTH-1:0]      quo_q, quo_d;

  // Write-back registers
  logic [WIDTH-1:0]      result_q, result_d;
  logic [REG_ADDR_W-1:0] result_reg_q, result_reg_d;

  // Per-iteration step values
  logic [WIDTH-1:0]      mul_addend;
  logic [WIDTH:0]        mul_sum;
  logic [2*WIDTH-1:0]    prod_step;
  logic [WIDTH:0]        div_shift;
  logic                  div_ge;
  logic [WIDTH-1:0]      rem_step;
  logic [WIDTH-1:0]      quo_step;

  logic                  accept;
  logic                  last_iter;

  assign accept    = (state_q == S_IDLE) && bus.start;
  assign last_iter = (state_q == S_RUN) && (cnt_q == '1);

  // One shift-add multiply step and one restoring divide step
  always_comb begin
    mul_addend = prod_q[0] ? opnd_q : '0;
    // Carry out of the accumulate is kept and shifted into the product
    mul_sum    = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, mul_addend};
    prod_step  = {mul_sum, prod_q[WIDTH-1:1]};

    // Shifted partial remainder is WIDTH+1 bits so the trial subtract
    // cannot overflow; the restored value is always below the divisor.
    div_shift  = {rem_q, quo_q[WIDTH-1]};
    div_ge     = (div_shift >= {1'b0, opnd_q});
    rem_step   = div_ge ? WIDTH'(div_shift - {1'b0, opnd_q})
                        : div_shift[WIDTH-1:0];
    quo_step   = {quo_q[WIDTH-2:0], div_ge};
  end

  // FSM state and iteration counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // FSM next state: accept in IDLE, WIDTH iterations in RUN, one DONE cycle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == '1) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Datapath next state: load on accept, iterate in RUN, capture result
  always_comb begin
    op_d         = op_q;
    dest_d       = dest_q;
    opnd_d       = opnd_q;
    prod_d       = prod_q;
    rem_d        = rem_q;
    quo_d        = quo_q;
    result_d     = result_q;
    result_reg_d = result_reg_q;

    if (accept) begin
      op_d   = bus.op;
      dest_d = bus.dest_reg;
      opnd_d = bus.op[1] ? bus.operand_b : bus.operand_a;
      prod_d = {{WIDTH{1'b0}}, bus.operand_b};
      rem_d  = '0;
      quo_d  = bus.operand_a;
    end else if (state_q == S_RUN) begin
      if (op_q[1]) begin
        rem_d = rem_step;
        quo_d = quo_step;
      end else begin
        prod_d = prod_step;
      end

      // Divide by zero falls out of the restoring algorithm naturally:
      // every trial succeeds (quotient all ones) and the remainder is
      // the dividend.
      if (last_iter) begin
        unique case (op_q)
          OP_MUL:   result_d = prod_step[WIDTH-1:0];
          OP_MULHU: result_d = prod_step[2*WIDTH-1:WIDTH];
          OP_DIVU:  result_d = quo_step;
          OP_REMU:  result_d = rem_step;
          default:  result_d = '0;
        endcase
        result_reg_d = dest_q;
      end
    end
  end

  // Datapath and write-back registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q         <= '0;
      dest_q       <= '0;
      opnd_q       <= '0;
      prod_q       <= '0;
      rem_q        <= '0;
      quo_q        <= '0;
      result_q     <= '0;
      result_reg_q <= '0;
    end else begin
      op_q         <= op_d;
      dest_q       <= dest_d;
      opnd_q       <= opnd_d;
      prod_q       <= prod_d;
      rem_q        <= rem_d;
      quo_q        <= quo_d;
      result_q     <= result_d;
      result_reg_q <= result_reg_d;
    end
  end

  // Status and write strobe decoded from registered state only; x0 is
  // never written.
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.done       = (state_q == S_DONE);
  assign bus.wb_en      = (state_q == S_DONE) && (result_reg_q != '0);
  assign bus.result     = result_q;
  assign bus.result_reg = result_reg_q;

endmodule
`default_nettype wire

// File: tb/tb_mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mul_div_unit
// Purpose  : Self-checking bench for mul_div_unit: directed scenarios plus
//            random operations against an arithmetic reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_mul_div_unit;

  logic clk = 1'b0;
  logic rst_n;

  int checks   = 0;
  int failures = 0;

  logic [63:0] prev_result = '0;
  logic [4:0]  prev_reg    = '0;

  mul_div_unit_if #(.WIDTH(64), .REG_ADDR_W(5)) bus ();

  mul_div_unit #(.WIDTH(64), .REG_ADDR_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain unsigned arithmetic on the full 128-bit product
  function automatic logic [63:0] ref_model(input logic [1:0] op,
                                            input logic [63:0] a,
                                            input logic [63:0] b);
    logic [127:0] p;
    p = {64'd0, a} * {64'd0, b};
    case (op)
      2'b00:   return p[63:0];
      2'b01:   return p[127:64];
      2'b10:   return (b == 64'd0) ? 64'hFFFF_FFFF_FFFF_FFFF : a / b;
      default: return (b == 64'd0) ? a : a % b;
    endcase
  endfunction

  task automatic scramble_inputs();
    bus.op        = 2'($urandom_range(0, 3));
    bus.operand_a = {$urandom, $urandom};
    bus.operand_b = {$urandom, $urandom};
    bus.dest_reg  = 5'($urandom_range(0, 31));
  endtask

  // Issue one operation and check every cycle until it has retired.
  // With restart set, start is re-asserted so that it is sampled at E10.
  task automatic run_op(input logic [1:0] op, input logic [63:0] a,
                        input logic [63:0] b, input logic [4:0] d,
                        input logic [63:0] exp, input bit restart);
    @(negedge clk);
    bus.start     = 1'b1;
    bus.op        = op;
    bus.operand_a = a;
    bus.operand_b = b;
    bus.dest_reg  = d;
    @(posedge clk);            // E0
    #1;
    bus.start = 1'b0;
    scramble_inputs();
    for (int k = 1; k <= 64; k++) begin
      @(negedge clk);          // between E(k-1) and Ek
      if (restart && k == 10) begin
        bus.start     = 1'b1;
        bus.op        = 2'b00;
        bus.operand_a = 64'd1000;
        bus.operand_b = 64'd1000;
      end
      if (restart && k == 11) bus.start = 1'b0;
      chk("run_flags", 128'({bus.busy, bus.done, bus.wb_en}), 128'(3'b100));
      chk("run_hold_result", 128'(bus.result), 128'(prev_result));
      chk("run_hold_reg", 128'(bus.result_reg), 128'(prev_reg));
    end
    @(negedge clk);            // between E64 and E65
    chk("done_flags", 128'({bus.busy, bus.done, bus.wb_en}),
        128'({1'b1, 1'b1, (d != 5'd0)}));
    chk("done_result", 128'(bus.result), 128'(exp));
    chk("done_reg", 128'(bus.result_reg), 128'(d));
    @(negedge clk);            // after E65
    chk("idle_flags", 128'({bus.busy, bus.done, bus.wb_en}), 128'(3'b000));
    chk("idle_result", 128'(bus.result), 128'(exp));
    prev_result = exp;
    prev_reg    = d;
  endtask

  initial begin
    logic [1:0]  rop;
    logic [63:0] ra, rb;
    logic [4:0]  rd;

    bus.start     = 1'b0;
    bus.op        = 2'b00;
    bus.operand_a = '0;
    bus.operand_b = '0;
    bus.dest_reg  = '0;
    rst_n         = 1'b1;
    #2 rst_n = 1'b0;
    #5;
    chk("reset_flags", 128'({bus.busy, bus.done, bus.wb_en}), 128'(3'b000));
    chk("reset_result", 128'(bus.result), 128'(0));
    chk("reset_reg", 128'(bus.result_reg), 128'(0));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Directed cases
    run_op(2'b00, 64'd7, 64'd6, 5'd3, 64'd42, 1'b0);
    run_op(2'b01, '1, '1, 5'd10, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
    run_op(2'b00, '1, '1, 5'd11, 64'd1, 1'b0);
    run_op(2'b10, 64'd100, 64'd7, 5'd5, 64'd14, 1'b0);
    run_op(2'b11, 64'd100, 64'd7, 5'd6, 64'd2, 1'b0);
    run_op(2'b10, 64'd5, 64'd0, 5'd7, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    run_op(2'b11, 64'd5, 64'd0, 5'd8, 64'd5, 1'b0);
    run_op(2'b00, 64'd3, 64'd5, 5'd9, 64'd15, 1'b1);

    // Asynchronous reset in the middle of a divide
    @(negedge clk);
    bus.start     = 1'b1;
    bus.op        = 2'b10;
    bus.operand_a = 64'd123456789;
    bus.operand_b = 64'd1000;
    bus.dest_reg  = 5'd12;
    @(posedge clk);            // E0
    #1 bus.start = 1'b0;
    repeat (30) @(posedge clk); // E30
    #2 rst_n = 1'b0;
    #1;
    chk("abort_flags", 128'({bus.busy, bus.done, bus.wb_en}), 128'(3'b000));
    chk("abort_result", 128'(bus.result), 128'(0));
    chk("abort_reg", 128'(bus.result_reg), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 70; k++) begin
      @(negedge clk);
      chk("abort_quiet", 128'({bus.busy, bus.done, bus.wb_en}), 128'(3'b000));
    end
    prev_result = '0;
    prev_reg    = '0;
    run_op(2'b00, 64'd2, 64'd2, 5'd4, 64'd4, 1'b0);
    run_op(2'b00, 64'd9, 64'd9, 5'd0, 64'd81, 1'b0);

    // Random operations against the reference model
    for (int n = 0; n < 24; n++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = {$urandom, $urandom};
      case ($urandom_range(0, 5))
        0:       rb = 64'd0;
        1:       rb = 64'($urandom_range(1, 300));
        2:       rb = {32'd0, $urandom};
        default: rb = {$urandom, $urandom};
      endcase
      rd = 5'($urandom_range(0, 31));
      run_op(rop, ra, rb, rd, ref_model(rop, ra, rb), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
